// File: rtl/adder_operand_pairer_if.sv
// Operand-pairer bus: serial operand input side plus the paired output
// that feeds a two-operand sequential adder.
// Ports: i_en/i_valid/i_data/i_last in, i_ready back; o_valid/o_data/o_en/o_last/o_pair_cnt out.
// Modports: master = the pairer (produces the pair), slave = the surrounding environment.
interface adder_operand_pairer_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
);
    logic                     i_en;
    logic                     i_valid;
    logic                     i_ready;
    logic [DATA_WIDTH-1:0]    i_data;
    logic                     i_last;
    logic [1:0]               o_valid;
    logic [2*DATA_WIDTH-1:0]  o_data;
    logic                     o_en;
    logic                     o_last;
    logic [COUNT_WIDTH-1:0]   o_pair_cnt;

    modport master (
        input  i_en, i_valid, i_data, i_last,
        output i_ready, o_valid, o_data, o_en, o_last, o_pair_cnt
    );

    modport slave (
        output i_en, i_valid, i_data, i_last,
        input  i_ready, o_valid, o_data, o_en, o_last, o_pair_cnt
    );
endinterface

// File: rtl/adder_operand_pairer.sv
// Purpose: packs a serial signed operand stream into {a,b} pairs, zero-padding odd groups.
// Latency: 1 cycle from the accept edge that completes a pair to the registered emit.
// Backpressure: i_ready follows i_en combinationally; i_en=0 freezes state, hold and count.
// Ports: clk, rst_n (async active-low), bus (adder_operand_pairer_if.master).
//   First operand of a pair lands on lane b (o_data low half), second on lane a (high half).
//   o_pair_cnt counts pairs within the current group and wraps modulo 2^COUNT_WIDTH.
module adder_operand_pairer #(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    adder_operand_pairer_if.master bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   hold_b;
    logic [COUNT_WIDTH-1:0]  cnt_reg;

    logic                    accept;
    logic                    emit;
    logic [DATA_WIDTH-1:0]   emit_a;
    logic [DATA_WIDTH-1:0]   emit_b;
    logic [COUNT_WIDTH-1:0]  cnt_inc;

    assign bus.i_ready = bus.i_en;
    assign accept      = bus.i_valid & bus.i_en;

    // A pair completes either on the second operand, or on a lone last
    // operand, which goes out on lane b with a zero pad on lane a.
    assign emit    = accept & ((state == HALF) | bus.i_last);
    assign emit_a  = (state == HALF) ? bus.i_data : '0;
    assign emit_b  = (state == HALF) ? hold_b     : bus.i_data;
    assign cnt_inc = cnt_reg + COUNT_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            hold_b         <= '0;
            cnt_reg        <= '0;
            bus.o_valid    <= 2'b00;
            bus.o_data     <= '0;
            bus.o_en       <= 1'b0;
            bus.o_last     <= 1'b0;
            bus.o_pair_cnt <= '0;
        end else begin
            bus.o_en    <= bus.i_en;
            // Idle cycles always show a clean zero pair.
            bus.o_valid <= 2'b00;
            bus.o_data  <= '0;
            bus.o_last  <= 1'b0;

            if (accept) begin
                if (state == EMPTY && !bus.i_last) begin
                    hold_b <= bus.i_data;
                    state  <= HALF;
                end else begin
                    state <= EMPTY;
                end
            end

            if (emit) begin
                bus.o_valid    <= 2'b11;
                bus.o_data     <= {emit_a, emit_b};
                bus.o_last     <= bus.i_last;
                bus.o_pair_cnt <= cnt_inc;
                // The closing pair still reports its own index; the next
                // group then starts counting from 1 again.
                cnt_reg        <= bus.i_last ? '0 : cnt_inc;
            end
        end
    end

endmodule
